// File: rtl/uart_rx.sv
// UART receiver: 4x oversampled start/data/parity/stop framing with a one-deep
// holding register, frame/parity error flags and a sticky overrun flag.
module uart_rx #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       baudtick,
  input  logic       rxd,
  input  logic       parity_en,
  input  logic       parity_odd,
  input  logic       rx_ready,
  input  logic       clr_overrun,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [2:0] {
    StIdle, StStart, StData, StParity, StStop, StWaitHigh
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_s;
  logic [1:0]             tcnt_q, tcnt_d;
  logic [2:0]             bidx_q, bidx_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_en_q, par_en_d, par_odd_q, par_odd_d, par_bit_q, par_bit_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d, frame_err_q, frame_err_d;
  logic                   parity_err_q, parity_err_d, overrun_q, overrun_d;
  logic                   complete;
  logic                   par_mismatch;

  assign rxd_s = sync_q[SYNC_STAGES-1];

  // Uses the options latched at the start bit so mid-frame changes are ignored.
  assign par_mismatch = par_en_q & ((^shift_q ^ par_bit_q) != par_odd_q);

  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    bidx_d    = bidx_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    par_bit_d = par_bit_q;
    complete  = 1'b0;
    if (baudtick) begin
      unique case (state_q)
        StIdle: begin
          if (!rxd_s) begin
            state_d   = StStart;
            tcnt_d    = 2'd0;
            par_en_d  = parity_en;
            par_odd_d = parity_odd;
          end
        end
        StStart: begin
          tcnt_d = tcnt_q + 2'd1;
          if (tcnt_q == 2'd2 && rxd_s) begin
            state_d = StIdle;
            tcnt_d  = 2'd0;
          end else if (tcnt_q == 2'd3) begin
            state_d = StData;
            bidx_d  = 3'd0;
          end
        end
        StData: begin
          tcnt_d = tcnt_q + 2'd1;
          if (tcnt_q == 2'd2) shift_d = {rxd_s, shift_q[7:1]};
          if (tcnt_q == 2'd3) begin
            if (bidx_q == 3'd7) state_d = par_en_q ? StParity : StStop;
            else                bidx_d  = bidx_q + 3'd1;
          end
        end
        StParity: begin
          tcnt_d = tcnt_q + 2'd1;
          if (tcnt_q == 2'd2) par_bit_d = rxd_s;
          if (tcnt_q == 2'd3) state_d = StStop;
        end
        StStop: begin
          tcnt_d = tcnt_q + 2'd1;
          if (tcnt_q == 2'd2) begin
            complete = 1'b1;
            tcnt_d   = 2'd0;
            state_d  = rxd_s ? StIdle : StWaitHigh;
          end
        end
        StWaitHigh: begin
          if (rxd_s) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    overrun_d    = overrun_q;
    if (clr_overrun) overrun_d = 1'b0;
    if (complete && (!rx_valid_q || rx_ready)) begin
      rx_data_d    = shift_q;
      rx_valid_d   = 1'b1;
      frame_err_d  = ~rxd_s;
      parity_err_d = par_mismatch;
    end else if (complete) begin
      overrun_d = 1'b1;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      sync_q       <= '1;
      tcnt_q       <= 2'd0;
      bidx_q       <= 3'd0;
      shift_q      <= 8'h00;
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      par_bit_q    <= 1'b0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= {sync_q[SYNC_STAGES-2:0], rxd};
      tcnt_q       <= tcnt_d;
      bidx_q       <= bidx_d;
      shift_q      <= shift_d;
      par_en_q     <= par_en_d;
      par_odd_q    <= par_odd_d;
      par_bit_q    <= par_bit_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != StIdle);

endmodule
